// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - register offsets, STATUS bit indices and FSM encoding for uart_mmio_bridge
package uart_bridge_pkg;

   localparam logic [3:0] TXDATA_OFS = 4'h0;
   localparam logic [3:0] RXDATA_OFS = 4'h4;
   localparam logic [3:0] STATUS_OFS = 4'h8;
   localparam logic [3:0] CTRL_OFS   = 4'hC;

   localparam int ST_W_READY = 0;
   localparam int ST_R_READY = 1;
   localparam int ST_TX_DROP = 2;
   localparam int ST_IE      = 3;
   localparam int CTRL_IE    = 0;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_TX_WAIT = 2'd1;
   localparam logic [1:0] S_RESP    = 2'd2;

   localparam logic [31:0] RX_EMPTY_WORD = 32'h8000_0000;

   // Registers are word-spaced, so only offset bits [3:2] select one.
   function automatic logic [1:0] reg_sel(input logic [3:0] ofs);
      return ofs[3:2];
   endfunction

endpackage

// File: rtl/uart_mmio_bridge.sv
// rtl/uart_mmio_bridge.sv - CPU word bus to UART TX/RX FIFO bridge; UART_MMIO_BRIDGE_IRQ_EN adds the RX irq output
module uart_mmio_bridge
   import uart_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int TX_TIMEOUT = 1024,
   parameter int TO_BITS    = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  bus_valid,
   input  logic                  bus_we,
   input  logic [ADDR_WIDTH-1:0] bus_addr,
   input  logic [31:0]           bus_wdata,
   output logic                  bus_ready,
   output logic [31:0]           bus_rdata,
   output logic [7:0]            w_data,
   output logic                  w_valid,
   input  logic                  w_ready,
   input  logic [7:0]            r_data,
   output logic                  r_valid,
   input  logic                  r_ready
`ifdef UART_MMIO_BRIDGE_IRQ_EN
   ,
   output logic                  irq
`endif
);

   localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);

   logic [1:0]         state_q,   state_d;
   logic [TO_BITS-1:0] cnt_q,     cnt_d;
   logic [7:0]         tx_byte_q, tx_byte_d;
   logic [7:0]         w_data_q,  w_data_d;
   logic               w_valid_q, w_valid_d;
   logic [31:0]        rdata_q,   rdata_d;
   logic               tx_drop_q, tx_drop_d;
   logic               ie_q,      ie_d;
   logic [1:0]         sel;
   logic [31:0]        status_word;
   logic               unused_bits;

   assign sel         = bus_addr[3:2];
   assign unused_bits = ^{bus_addr, bus_wdata};
   assign status_word = {28'd0, ie_q, tx_drop_q, r_ready, w_ready};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_byte_d = tx_byte_q;
      w_data_d  = w_data_q;
      w_valid_d = 1'b0;
      rdata_d   = 32'd0;
      tx_drop_d = tx_drop_q;
      ie_d      = ie_q;
      r_valid   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus_valid && !bus_we) begin
               state_d = S_RESP;
               if (sel == reg_sel(RXDATA_OFS)) begin
                  if (r_ready) begin
                     r_valid = 1'b1;
                     rdata_d = {24'd0, r_data};
                  end else begin
                     rdata_d = RX_EMPTY_WORD;
                  end
               end else if (sel == reg_sel(STATUS_OFS)) begin
                  rdata_d = status_word;
               end else if (sel == reg_sel(CTRL_OFS)) begin
                  rdata_d = {31'd0, ie_q};
               end
            end else if (bus_valid) begin
               state_d = S_RESP;
               if (sel == reg_sel(TXDATA_OFS)) begin
                  tx_byte_d = bus_wdata[7:0];
                  if (w_ready) begin
                     w_valid_d = 1'b1;
                     w_data_d  = bus_wdata[7:0];
                  end else begin
                     cnt_d   = '0;
                     state_d = S_TX_WAIT;
                  end
               end else if (sel == reg_sel(STATUS_OFS)) begin
                  if (bus_wdata[ST_TX_DROP]) tx_drop_d = 1'b0;
               end else if (sel == reg_sel(CTRL_OFS)) begin
                  ie_d = bus_wdata[CTRL_IE];
               end
            end
         end
         S_TX_WAIT: begin
            // The byte is latched, so the push does not depend on bus_wdata still being held.
            if (w_ready) begin
               w_valid_d = 1'b1;
               w_data_d  = tx_byte_q;
               state_d   = S_RESP;
            end else if ((TX_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               tx_drop_d = 1'b1;
               state_d   = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tx_byte_q <= 8'd0;
         w_data_q  <= 8'd0;
         w_valid_q <= 1'b0;
         rdata_q   <= 32'd0;
         tx_drop_q <= 1'b0;
         ie_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tx_byte_q <= tx_byte_d;
         w_data_q  <= w_data_d;
         w_valid_q <= w_valid_d;
         rdata_q   <= rdata_d;
         tx_drop_q <= tx_drop_d;
         ie_q      <= ie_d;
      end
   end

   assign bus_ready = (state_q == S_RESP);
   assign bus_rdata = rdata_q;
   assign w_data    = w_data_q;
   assign w_valid   = w_valid_q;

`ifdef UART_MMIO_BRIDGE_IRQ_EN
   logic irq_q, irq_d;

   assign irq_d = ie_q & r_ready;

   always_ff @(posedge CLK) begin
      if (RST) irq_q <= 1'b0;
      else     irq_q <= irq_d;
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb/tb_uart_mmio_bridge.sv - self-checking bench for uart_mmio_bridge (irq checks under UART_MMIO_BRIDGE_IRQ_EN)
module tb_uart_mmio_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_valid = 1'b0;
   logic        bus_we = 1'b0;
   logic [3:0]  bus_addr = 4'h0;
   logic [31:0] bus_wdata = 32'd0;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic [7:0]  w_data;
   logic        w_valid;
   logic        w_ready = 1'b0;
   logic [7:0]  r_data = 8'd0;
   logic        r_valid;
   logic        r_ready = 1'b0;
`ifdef UART_MMIO_BRIDGE_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int failures = 0;
   int rpops = 0;
   logic [31:0] rq[$];
   logic [7:0]  wq[$];

   typedef struct {
      logic        we;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic        wr;
      logic        rr;
      logic [7:0]  rd;
      logic [31:0] exp;
      bit          push;
      int          pops;
   } vec_t;

   vec_t vecs[14];

   always #5 clk = ~clk;

   uart_mmio_bridge #(.ADDR_WIDTH(4), .TX_TIMEOUT(8), .TO_BITS(16)) dut (
      .CLK(clk), .RST(rst),
      .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata),
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
      .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready)
`ifdef UART_MMIO_BRIDGE_IRQ_EN
      , .irq(irq)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard: responses and TX pushes are popped as the DUT produces them.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_ready) begin
            if (rq.size() == 0) check("unexpected_bus_ready", {31'd0, bus_ready}, 32'd0);
            else                check("bus_rdata", bus_rdata, rq.pop_front());
         end else begin
            check("rdata_zero_when_idle", bus_rdata, 32'd0);
         end
         if (w_valid) begin
            if (wq.size() == 0) check("unexpected_w_valid", {31'd0, w_valid}, 32'd0);
            else                check("w_data", {24'd0, w_data}, {24'd0, wq.pop_front()});
         end
         if (r_valid) begin
            rpops++;
            check("r_valid_needs_r_ready", {31'd0, r_ready}, 32'd1);
         end
      end
   end

   // Caller is positioned #1 after a rising edge; returns one cycle after bus_ready.
   task automatic do_op(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int exp_lat, input bit push,
                        input string name);
      int k = 0;
      rq.push_back(exp_rdata);
      if (push) wq.push_back(wdata[7:0]);
      bus_valid = 1'b1;
      bus_we    = we;
      bus_addr  = addr;
      bus_wdata = wdata;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!bus_ready && k < 50);
      bus_valid = 1'b0;
      bus_we    = 1'b0;
      check({name, "_latency"}, k, exp_lat);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int rp0;
      vecs[0]  = '{1'b1, 4'h0, 32'h0000_0141, 1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 0};
      vecs[1]  = '{1'b0, 4'h4, 32'h0,         1'b1, 1'b1, 8'h5A, 32'h0000_005A, 1'b0, 1};
      vecs[2]  = '{1'b0, 4'h4, 32'h0,         1'b1, 1'b0, 8'h5A, 32'h8000_0000, 1'b0, 0};
      vecs[3]  = '{1'b0, 4'h8, 32'h0,         1'b1, 1'b0, 8'h00, 32'h0000_0001, 1'b0, 0};
      vecs[4]  = '{1'b0, 4'h8, 32'h0,         1'b0, 1'b1, 8'hC3, 32'h0000_0002, 1'b0, 0};
      vecs[5]  = '{1'b1, 4'hC, 32'h0000_0001, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 0};
      vecs[6]  = '{1'b0, 4'hC, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0000_0001, 1'b0, 0};
      vecs[7]  = '{1'b0, 4'h8, 32'h0,         1'b1, 1'b1, 8'h11, 32'h0000_000B, 1'b0, 0};
      vecs[8]  = '{1'b1, 4'hC, 32'hFFFF_FFFE, 1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 0};
      vecs[9]  = '{1'b0, 4'hC, 32'h0,         1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 0};
      vecs[10] = '{1'b0, 4'h0, 32'h0,         1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 0};
      vecs[11] = '{1'b1, 4'h4, 32'h0000_0055, 1'b1, 1'b1, 8'h99, 32'h0000_0000, 1'b0, 0};
      vecs[12] = '{1'b0, 4'h4, 32'h0,         1'b0, 1'b1, 8'hA5, 32'h0000_00A5, 1'b0, 1};
      vecs[13] = '{1'b1, 4'h0, 32'hFFFF_FFAB, 1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 0};

      repeat (3) @(posedge clk);
      #1;
      check("reset_bus_ready", {31'd0, bus_ready}, 32'd0);
      check("reset_bus_rdata", bus_rdata, 32'd0);
      check("reset_w_valid", {31'd0, w_valid}, 32'd0);
      check("reset_w_data", {24'd0, w_data}, 32'd0);
`ifdef UART_MMIO_BRIDGE_IRQ_EN
      check("reset_irq", {31'd0, irq}, 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         w_ready = vecs[i].wr;
         r_ready = vecs[i].rr;
         r_data  = vecs[i].rd;
         rp0     = rpops;
         do_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1, vecs[i].push,
               $sformatf("vec%0d", i));
         check($sformatf("vec%0d_pops", i), rpops - rp0, vecs[i].pops);
      end

      // Blocked store times out after 8 wait cycles and sets the sticky drop flag.
      w_ready = 1'b0;
      r_ready = 1'b0;
      do_op(1'b1, 4'h0, 32'h33, 32'h0, 9, 1'b0, "timeout_store");
      do_op(1'b0, 4'h8, 32'h0, 32'h4, 1, 1'b0, "status_drop");
      do_op(1'b1, 4'h8, 32'h4, 32'h0, 1, 1'b0, "clear_drop");
      do_op(1'b0, 4'h8, 32'h0, 32'h0, 1, 1'b0, "status_cleared");

      // w_ready rises after three blocked cycles; push follows one cycle later.
      fork
         do_op(1'b1, 4'h0, 32'h77, 32'h0, 4, 1'b1, "late_ready_store");
         begin
            repeat (3) @(posedge clk);
            #1;
            w_ready = 1'b1;
         end
      join
      do_op(1'b0, 4'h8, 32'h0, 32'h1, 1, 1'b0, "status_no_drop");

      // Reset while a store is parked in TX_WAIT.
      w_ready   = 1'b0;
      bus_valid = 1'b1;
      bus_we    = 1'b1;
      bus_addr  = 4'h0;
      bus_wdata = 32'h99;
      repeat (3) @(posedge clk);
      #1;
      rst       = 1'b1;
      bus_valid = 1'b0;
      bus_we    = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_bus_ready", {31'd0, bus_ready}, 32'd0);
      check("midrst_bus_rdata", bus_rdata, 32'd0);
      check("midrst_w_valid", {31'd0, w_valid}, 32'd0);
      check("midrst_w_data", {24'd0, w_data}, 32'd0);
      rst     = 1'b0;
      w_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check("after_rst_quiet", {30'd0, bus_ready, w_valid}, 32'd0);
      end
      do_op(1'b0, 4'h8, 32'h0, 32'h1, 1, 1'b0, "status_after_rst");

`ifdef UART_MMIO_BRIDGE_IRQ_EN
      r_ready = 1'b0;
      do_op(1'b1, 4'hC, 32'h1, 32'h0, 1, 1'b0, "irq_enable");
      r_ready = 1'b1;
      r_data  = 8'h3C;
      check("irq_lag_low", {31'd0, irq}, 32'd0);
      @(posedge clk);
      #1;
      check("irq_raised", {31'd0, irq}, 32'd1);
      rp0 = rpops;
      do_op(1'b0, 4'h4, 32'h0, 32'h3C, 1, 1'b0, "irq_pop");
      check("irq_pop_count", rpops - rp0, 1);
      r_ready = 1'b0;
      check("irq_still_high", {31'd0, irq}, 32'd1);
      @(posedge clk);
      #1;
      check("irq_cleared", {31'd0, irq}, 32'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("tx_queue_drained", wq.size(), 32'd0);
      check("resp_queue_drained", rq.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
